// File: rtl/bram_port_master.sv
// Streaming initiator for one BRAM port. It issues commands in order, tracks the
// fixed read latency, and returns read data through a credit-guarded FWFT FIFO.
module bram_port_master #(
  parameter int unsigned ADDR_W    = 8,
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned RD_LAT    = 1,
  parameter int unsigned RSP_DEPTH = 4
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_we,
  input  logic [ADDR_W-1:0]              req_addr,
  input  logic [DATA_W-1:0]              req_wdata,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [DATA_W-1:0]              rsp_rdata,
  output logic                           bram_en,
  output logic                           bram_we,
  output logic [ADDR_W-1:0]              bram_addr,
  output logic [DATA_W-1:0]              bram_din,
  input  logic [DATA_W-1:0]              bram_dout,
  output logic [$clog2(RSP_DEPTH+1)-1:0] rd_pending
);

  localparam int unsigned PEND_W = $clog2(RSP_DEPTH + 1);
  localparam int unsigned PTR_W  = $clog2(RSP_DEPTH);

  logic              req_acc;
  logic              rd_acc;
  logic              rsp_pop;
  logic              rsp_push;
  logic              fifo_full;

  logic [PEND_W-1:0] pend_q, pend_d;
  logic              en_q, en_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] din_q, din_d;
  logic [RD_LAT-1:0] rdv_q, rdv_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PEND_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] fifo_mem [RSP_DEPTH];

  // Handshakes; a read is only accepted while a FIFO slot is reserved for it
  always_comb begin
    req_ready = !rst && (pend_q < PEND_W'(RSP_DEPTH));
    req_acc   = req_valid && req_ready;
    rd_acc    = req_acc && !req_we;
    rsp_valid = !rst && (cnt_q != '0);
    rsp_pop   = rsp_valid && rsp_ready;
    rsp_push  = rdv_q[RD_LAT-1];
    rsp_rdata = fifo_mem[rd_ptr_q];
    fifo_full = (cnt_q == PEND_W'(RSP_DEPTH));
  end

  // Next-state: credits, issue stage, read-valid shift, FIFO pointers
  always_comb begin
    pend_d   = pend_q;
    en_d     = req_acc;
    we_d     = req_acc && req_we;
    addr_d   = addr_q;
    din_d    = din_q;
    rdv_d    = RD_LAT'({rdv_q, (en_q && !we_q)});
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;

    if (rd_acc && !rsp_pop) begin
      pend_d = pend_q + PEND_W'(1);
    end else if (!rd_acc && rsp_pop) begin
      pend_d = pend_q - PEND_W'(1);
    end

    if (req_acc) begin
      addr_d = req_addr;
      din_d  = req_wdata;
    end

    if (rsp_push) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rsp_pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (rsp_push && !rsp_pop) begin
      cnt_d = cnt_q + PEND_W'(1);
    end else if (!rsp_push && rsp_pop) begin
      cnt_d = cnt_q - PEND_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q   <= '0;
      en_q     <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      rdv_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      pend_q   <= pend_d;
      en_q     <= en_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
      rdv_q    <= rdv_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage needs no reset; occupancy lives in cnt_q
  always_ff @(posedge clk) begin
    if (!rst && rsp_push) begin
      fifo_mem[wr_ptr_q] <= bram_dout;
    end
  end

  assign bram_en    = en_q;
  assign bram_we    = we_q;
  assign bram_addr  = addr_q;
  assign bram_din   = din_q;
  assign rd_pending = pend_q;

  // Credits make a push into a full FIFO impossible unless the same edge pops
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(rsp_push && fifo_full && !rsp_pop));

endmodule

// File: tb/tb_bram_port_master.sv
// Bench for bram_port_master: one instance per read latency (1 and 2), each with
// its own BRAM model, compared every cycle against a transaction-level model.
module tb_bram_port_master;

  localparam int unsigned AW    = 8;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned PW    = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic          rst        [2];
  logic          req_valid  [2];
  logic          req_ready  [2];
  logic          req_we     [2];
  logic [AW-1:0] req_addr   [2];
  logic [DW-1:0] req_wdata  [2];
  logic          rsp_valid  [2];
  logic          rsp_ready  [2];
  logic [DW-1:0] rsp_rdata  [2];
  logic          bram_en    [2];
  logic          bram_we    [2];
  logic [AW-1:0] bram_addr  [2];
  logic [DW-1:0] bram_din   [2];
  logic [DW-1:0] bram_dout  [2];
  logic [PW-1:0] rd_pending [2];

  bram_port_master #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(1), .RSP_DEPTH(DEPTH)) u_lat1 (
    .clk(clk), .rst(rst[0]),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
    .bram_en(bram_en[0]), .bram_we(bram_we[0]), .bram_addr(bram_addr[0]),
    .bram_din(bram_din[0]), .bram_dout(bram_dout[0]), .rd_pending(rd_pending[0])
  );

  bram_port_master #(.ADDR_W(AW), .DATA_W(DW), .RD_LAT(2), .RSP_DEPTH(DEPTH)) u_lat2 (
    .clk(clk), .rst(rst[1]),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
    .bram_en(bram_en[1]), .bram_we(bram_we[1]), .bram_addr(bram_addr[1]),
    .bram_din(bram_din[1]), .bram_dout(bram_dout[1]), .rd_pending(rd_pending[1])
  );

  // BRAM models: latency 1 for instance 0, an extra output register for instance 1
  logic [DW-1:0] bram_mem [2][256];
  logic [DW-1:0] bram_q1  [2];
  logic [DW-1:0] bram_q2;
  assign bram_dout[0] = bram_q1[0];
  assign bram_dout[1] = bram_q2;

  initial begin
    for (int d = 0; d < 2; d++)
      for (int a = 0; a < 256; a++) bram_mem[d][a] = DW'(a ^ 32'hFF);
    forever begin
      @(posedge clk);
      for (int d = 0; d < 2; d++) begin
        if (bram_en[d] === 1'b1) begin
          if (bram_we[d] === 1'b1) bram_mem[d][bram_addr[d]] <= bram_din[d];
          else                     bram_q1[d] <= bram_mem[d][bram_addr[d]];
        end
      end
      bram_q2 <= bram_q1[1];
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic [DW-1:0] data;
    int unsigned   due;
  } rsp_t;

  // Reference: memory contents, outstanding reads with the cycle each becomes visible
  for (genvar g = 0; g < 2; g++) begin : mdl
    localparam int unsigned LAT = g + 1;
    logic [DW-1:0] ref_mem [256];
    rsp_t          q [$];
    int unsigned   pend;
    logic          exp_en, exp_we, exp_valid, acc, pop;
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_din;
    string         pfx;

    initial begin
      pfx = $sformatf("lat%0d ", LAT);
      for (int a = 0; a < 256; a++) ref_mem[a] = DW'(a ^ 32'hFF);
      pend = 0; exp_en = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_din = '0;
      forever begin
        @(negedge clk);
        if (rst[g] === 1'b1) begin
          check({pfx, "req_ready in reset"}, 32'(req_ready[g]), 32'(0));
          check({pfx, "rsp_valid in reset"}, 32'(rsp_valid[g]), 32'(0));
          q.delete();
          pend = 0; exp_en = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_din = '0;
        end else begin
          exp_valid = (q.size() > 0) && (q[0].due <= cyc);
          acc       = req_valid[g] && (pend < DEPTH);
          check({pfx, "req_ready"},  32'(req_ready[g]),  32'(pend < DEPTH));
          check({pfx, "rd_pending"}, 32'(rd_pending[g]), 32'(pend));
          check({pfx, "bram_en"},    32'(bram_en[g]),    32'(exp_en));
          check({pfx, "bram_we"},    32'(bram_we[g]),    32'(exp_we));
          check({pfx, "bram_addr"},  32'(bram_addr[g]),  32'(exp_addr));
          check({pfx, "bram_din"},   32'(bram_din[g]),   32'(exp_din));
          check({pfx, "rsp_valid"},  32'(rsp_valid[g]),  32'(exp_valid));
          if (exp_valid) check({pfx, "rsp_rdata"}, 32'(rsp_rdata[g]), 32'(q[0].data));
          pop = exp_valid && rsp_ready[g];
          if (pop) begin
            void'(q.pop_front());
            pend--;
          end
          exp_en = acc;
          exp_we = acc && req_we[g];
          if (acc) begin
            exp_addr = req_addr[g];
            exp_din  = req_wdata[g];
            if (req_we[g]) ref_mem[req_addr[g]] = req_wdata[g];
            else begin
              q.push_back('{ref_mem[req_addr[g]], cyc + LAT + 2});
              pend++;
            end
          end
        end
      end
    end
  end

  task automatic idle(input int d);
    req_valid[d] = 1'b0; req_we[d] = 1'b0; req_addr[d] = '0; req_wdata[d] = '0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // One command; returns just after its accepting edge
  task automatic send(input int d, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] w);
    int   waited;
    logic acc;
    waited = 0; acc = 1'b0;
    req_valid[d] = 1'b1; req_we[d] = we; req_addr[d] = a; req_wdata[d] = w;
    while (!acc && waited < 50) begin
      @(negedge clk);
      acc = req_ready[d];
      @(posedge clk); #1;
      waited++;
    end
    if (!acc) check("send timeout", 32'(0), 32'(1));
    req_valid[d] = 1'b0;
  endtask

  // Hold a read request for ncyc cycles, stepping the address on every accept
  task automatic drive_reads(input int d, input int base, input int ncyc, output int got);
    got = 0;
    for (int c = 0; c < ncyc; c++) begin
      req_valid[d] = 1'b1; req_we[d] = 1'b0; req_addr[d] = AW'(base + got);
      @(negedge clk);
      if (req_ready[d]) got++;
      @(posedge clk); #1;
    end
    req_valid[d] = 1'b0;
  endtask

  task automatic run_tests(input int d);
    int n, got;
    string pfx;
    pfx = $sformatf("lat%0d ", d + 1);
    rsp_ready[d] = 1'b1;

    send(d, 1'b1, 8'h10, 8'h5A);
    @(negedge clk);
    check({pfx, "write issue en"},   32'(bram_en[d]),   32'(1));
    check({pfx, "write issue we"},   32'(bram_we[d]),   32'(1));
    check({pfx, "write issue addr"}, 32'(bram_addr[d]), 32'h10);
    check({pfx, "write issue din"},  32'(bram_din[d]),  32'h5A);
    @(posedge clk); #1;

    send(d, 1'b0, 8'h10, 8'h00);
    n = 1;
    forever begin
      @(negedge clk);
      if (rsp_valid[d] || n >= 20) break;
      @(posedge clk); #1;
      n++;
    end
    check({pfx, "read latency"},      32'(n),            32'(d + 3));
    check({pfx, "read after write"},  32'(rsp_rdata[d]), 32'h5A);
    @(posedge clk); #1;
    wait_cycles(4);

    for (int a = 0; a < 8; a++) send(d, 1'b0, AW'(a), 8'h00);
    wait_cycles(10);

    rsp_ready[d] = 1'b0;
    drive_reads(d, 32'h20, 12, got);
    check({pfx, "accepted under backpressure"}, 32'(got), 32'(4));
    @(negedge clk);
    check({pfx, "pending when full"}, 32'(rd_pending[d]), 32'(4));
    check({pfx, "ready when full"},   32'(req_ready[d]),  32'(0));
    @(posedge clk); #1;
    rsp_ready[d] = 1'b1;
    wait_cycles(12);

    rsp_ready[d] = 1'b0;
    drive_reads(d, 32'h30, 3, got);
    wait_cycles(6);
    rsp_ready[d] = 1'b1;
    drive_reads(d, 32'h40, 1, got);
    rsp_ready[d] = 1'b0;
    @(negedge clk);
    check({pfx, "pending on accept+pop"}, 32'(rd_pending[d]), 32'(3));
    @(posedge clk); #1;
    rsp_ready[d] = 1'b1;
    wait_cycles(12);

    drive_reads(d, 32'h50, 3, got);
    rst[d] = 1'b1;
    @(posedge clk); #1;
    rst[d] = 1'b0;
    @(negedge clk);
    check({pfx, "pending after reset"}, 32'(rd_pending[d]), 32'(0));
    check({pfx, "en after reset"},      32'(bram_en[d]),    32'(0));
    check({pfx, "valid after reset"},   32'(rsp_valid[d]),  32'(0));
    @(posedge clk); #1;
    wait_cycles(6);
    send(d, 1'b0, 8'h10, 8'h00);
    wait_cycles(8);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < 2; d++) begin
      rst[d] = 1'b1; rsp_ready[d] = 1'b0;
      idle(d);
    end
    repeat (3) @(posedge clk);
    #1;
    rst[0] = 1'b0; rst[1] = 1'b0;
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      check($sformatf("lat%0d ready after reset", d + 1),   32'(req_ready[d]),  32'(1));
      check($sformatf("lat%0d pending after reset", d + 1), 32'(rd_pending[d]), 32'(0));
      check($sformatf("lat%0d en after reset", d + 1),      32'(bram_en[d]),    32'(0));
      check($sformatf("lat%0d valid after reset", d + 1),   32'(rsp_valid[d]),  32'(0));
    end
    @(posedge clk); #1;

    for (int d = 0; d < 2; d++) run_tests(d);

    // Random mix on both instances, small address range to hit read-after-write
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++) begin
        req_valid[d] = ($urandom_range(0, 3) != 0);
        req_we[d]    = ($urandom_range(0, 2) == 0);
        req_addr[d]  = AW'($urandom_range(0, 15));
        req_wdata[d] = DW'($urandom);
        rsp_ready[d] = ($urandom_range(0, 3) != 0);
        rst[d]       = ($urandom_range(0, 99) == 0);
      end
      @(posedge clk); #1;
    end
    for (int d = 0; d < 2; d++) begin
      idle(d);
      rst[d] = 1'b0;
      rsp_ready[d] = 1'b1;
    end
    wait_cycles(15);
    @(negedge clk);
    for (int d = 0; d < 2; d++)
      check($sformatf("lat%0d drained", d + 1), 32'(rd_pending[d]), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
